// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with round-based debounce and a 32-bit nibble-shift value register.
// Optional build macro KEYPAD_OVERFLOW_LOCK_EN freezes the value once eight digits are entered.
module hex_keypad_entry #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    input  logic        clr_in,
    output logic [3:0]  col_out,
    output logic [31:0] value_out,
    output logic [3:0]  digit_count,
    output logic        key_strobe,
    output logic [3:0]  key_code
);
    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    logic [3:0]        r_row_s1;
    logic [3:0]        r_row_s2;
    logic [SLOT_W-1:0] r_slot;
    logic [1:0]        r_col;
    logic [1:0]        r_hits;
    logic [3:0]        r_hit_code;
    state_t            r_state;
    logic [3:0]        r_cand;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_strobe;
    logic [3:0]        r_key_code;
    logic [31:0]       r_value;
    logic [3:0]        r_count;

    logic              w_slot_last;
    logic              w_eval;
    logic [2:0]        w_col_hits;
    logic [3:0]        w_col_code;
    logic [2:0]        w_sum;
    logic [1:0]        w_tot;
    logic [3:0]        w_round_code;
    logic              w_is_key;
    logic              w_is_none;
    state_t            w_state_nx;
    logic [3:0]        w_cand_nx;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_accept;
    logic              w_locked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= row_in;
            r_row_s2 <= r_row_s1;
        end
    end

    assign w_slot_last = (r_slot == SLOT_W'(SCAN_DIV - 1));
    assign w_eval      = w_slot_last && (r_col == 2'd3);

    // Hits seen in the currently strobed column; a single hit yields its code.
    always_comb begin
        w_col_hits = 3'd0;
        w_col_code = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (!r_row_s2[r]) begin
                w_col_hits = w_col_hits + 3'd1;
                w_col_code = {2'(r), r_col};
            end
        end
    end

    assign w_sum        = {1'b0, r_hits} + w_col_hits;
    assign w_tot        = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_round_code = (r_hits == 2'd0) ? w_col_code : r_hit_code;
    assign w_is_key     = (w_tot == 2'd1);
    assign w_is_none    = (w_tot == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot     <= '0;
            r_col      <= 2'd0;
            r_hits     <= 2'd0;
            r_hit_code <= 4'd0;
        end else if (w_slot_last) begin
            r_slot <= '0;
            r_col  <= r_col + 2'd1;
            if (r_col == 2'd3) begin
                r_hits <= 2'd0;
            end else begin
                r_hits     <= w_tot;
                r_hit_code <= w_round_code;
            end
        end else begin
            r_slot <= r_slot + SLOT_W'(1);
        end
    end

    assign col_out   = ~(4'b0001 << r_col);
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nx = r_state;
        w_cand_nx  = r_cand;
        w_cnt_nx   = r_cnt;
        w_accept   = 1'b0;
        if (w_eval) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_key) begin
                        w_cand_nx = w_round_code;
                        w_cnt_nx  = CNT_W'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            w_accept   = 1'b1;
                            w_state_nx = ST_PRESSED;
                        end else begin
                            w_state_nx = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_is_key && (w_round_code == r_cand)) begin
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc >= CNT_W'(DEBOUNCE_SCANS)) begin
                            w_accept   = 1'b1;
                            w_state_nx = ST_PRESSED;
                        end
                    end else if (w_is_key) begin
                        w_cand_nx = w_round_code;
                        w_cnt_nx  = CNT_W'(1);
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (w_is_none) begin
                        w_cnt_nx   = CNT_W'(1);
                        w_state_nx = (DEBOUNCE_SCANS == 1) ? ST_IDLE : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (w_is_none) begin
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc >= CNT_W'(DEBOUNCE_SCANS)) begin
                            w_state_nx = ST_IDLE;
                        end
                    end else begin
                        w_state_nx = ST_PRESSED;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cand     <= 4'd0;
            r_cnt      <= '0;
            r_strobe   <= 1'b0;
            r_key_code <= 4'd0;
        end else begin
            r_state  <= w_state_nx;
            r_cand   <= w_cand_nx;
            r_cnt    <= w_cnt_nx;
            r_strobe <= w_accept;
            if (w_accept) begin
                r_key_code <= w_cand_nx;
            end
        end
    end

`ifdef KEYPAD_OVERFLOW_LOCK_EN
    assign w_locked = (r_count == 4'd8);
`else
    assign w_locked = 1'b0;
`endif

    // The value register consumes the strobe cycle, so a clear in that cycle lands first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= 32'd0;
            r_count <= 4'd0;
        end else if (r_strobe && clr_in) begin
            r_value <= {28'd0, r_key_code};
            r_count <= 4'd1;
        end else if (clr_in) begin
            r_value <= 32'd0;
            r_count <= 4'd0;
        end else if (r_strobe && !w_locked) begin
            r_value <= {r_value[27:0], r_key_code};
            if (r_count != 4'd8) begin
                r_count <= r_count + 4'd1;
            end
        end
    end

    assign value_out   = r_value;
    assign digit_count = r_count;
    assign key_strobe  = r_strobe;
    assign key_code    = r_key_code;
endmodule
